timer_prog: RTL
===============

TIMER_PROG -- requirements
Module: timer_prog

Interface
REQ-001 Parameter WIDTH, default 12, counter and period width in bits.
REQ-002 Parameter CHANNELS, default 2, number of independent timer channels.
REQ-003 Parameter DEFAULT_PERIOD, default 434, period loaded into every channel at reset.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  CHANNELS  per-channel count enable; low pauses the channel.
REQ-007 Port mode  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot.
REQ-008 Port load  input  CHANNELS  per-channel strobe that loads the period and restarts the channel.
REQ-009 Port period_in  input  WIDTH  shared period value, captured by any channel whose load bit is high.
REQ-010 Port rollover  output  CHANNELS  per-channel terminal-count pulse.
REQ-011 Port busy  output  CHANNELS  per-channel running indicator.

Function
REQ-012 Each channel SHALL hold a WIDTH-bit counter cnt, a WIDTH-bit period register per, and an armed flag.
REQ-013 busy[c] SHALL equal enable[c] AND (per != 0) AND (mode[c] == periodic OR armed).
REQ-014 rollover[c] SHALL be a combinational decode of registered state: high exactly in cycles where busy[c] = 1 and cnt == per - 1.
REQ-015 At an edge with busy[c] = 1 and no load, cnt SHALL increment; on cnt == per - 1 it SHALL wrap to 0.
REQ-016 At an edge with busy[c] = 0 and no load, cnt, per and armed SHALL hold. The enable gap pauses the count; it does not clear it.
REQ-017 Load on channel c at an edge SHALL set per = period_in, cnt = 0 and armed = 1, whatever the current enable or mode.
REQ-018 Load coinciding with a terminal count SHALL take priority. The combinational rollover of that cycle is still emitted, and the next state is cnt = 0.
REQ-019 In one-shot mode, the edge that ends a terminal-count cycle SHALL clear armed and set cnt = 0. No further rollover occurs until the next load.
REQ-020 Changing mode while a channel is busy SHALL take effect from the next edge. Switching to periodic resumes counting from the current cnt.
REQ-021 per = 1 SHALL give rollover high in every busy cycle. per = 0 SHALL keep busy and rollover low.
REQ-022 The maximum period SHALL be 2^WIDTH - 1 cycles. The counter never exceeds per - 1, and arithmetic is modulo 2^WIDTH only through the explicit wrap.
REQ-023 Channels SHALL be fully independent. The same period_in value SHALL be captured by every channel whose load bit is high in the same cycle.

Reset
REQ-024 While reset is high, every channel SHALL immediately have cnt = 0, per = DEFAULT_PERIOD and armed = 0, with no clock required.
REQ-025 While reset is high, rollover and busy SHALL be 0 for all channels.
REQ-026 After reset release, periodic channels SHALL run on enable alone, while one-shot channels SHALL require a load before running.
REQ-027 Reset asserted mid-count SHALL abandon the count. Any pending one-shot is discarded.

Structure
REQ-028 Shared package timer_pkg SHALL hold the mode encoding constants (MODE_PERIODIC = 0, MODE_ONESHOT = 1) and the default parameter values.
REQ-029 The per-channel logic SHALL be one sub-module, timer_channel, instantiated CHANNELS times by a generate loop in timer_prog.
REQ-030 Elaboration SHALL fail if DEFAULT_PERIOD > 2^WIDTH - 1 or CHANNELS < 1.

Verification
REQ-031 Release reset, hold enable[0] = 1 in periodic mode from cycle 0 with default parameters -> rollover[0] is high in cycles 433, 867 and 1301 only, one cycle each.
REQ-032 Load ch1 with period_in = 5 at edge L, enable high -> rollover[1] is high in cycles L+4, L+9 and L+14, while ch0 is unaffected.
REQ-033 Load ch0 with period_in = 3 in one-shot mode, enable high -> rollover[0] is high only in cycle L+2, busy[0] is low from L+3, and no further pulses occur for 20 cycles.
REQ-034 Periodic ch0 with period 5, deassert enable for 4 cycles when cnt = 2 -> cnt holds at 2, and the next rollover is delayed by exactly 4 cycles.
REQ-035 Assert reset asynchronously between edges when cnt = 300 -> rollover and busy drop immediately, and after release the first rollover is in cycle 433.
REQ-036 Load period 1 -> rollover is high every enabled cycle; load period 0 -> busy = 0 and rollover stays 0 for 10 cycles; load in a terminal-count cycle -> pulse is emitted and cnt = 0 next cycle.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared definitions for the programmable timer block.
//               Holds the per-channel mode encoding and the default values of
//               the top-level parameters.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Per-channel mode encoding (one bit per channel on the mode port)
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Default parameter values for timer_prog / timer_channel
  localparam int DEF_WIDTH    = 12;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_PERIOD   = 434;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One independent timer channel. Counts 0 .. per-1 while busy,
//               flags the terminal count combinationally, and supports
//               periodic and one-shot operation with a load/restart strobe.
// Ports       : clk       - clock, state updates on rising edge
//               reset     - asynchronous active-high reset
//               enable    - count enable (low pauses, does not clear)
//               mode      - 0 = periodic, 1 = one-shot
//               load      - capture period_in and restart the count
//               period_in - period value captured on load
//               rollover  - terminal-count pulse (decode of registered state)
//               busy      - channel is actively counting this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic             rollover,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_rst_period = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             armed_q, armed_d;

  logic             w_busy;
  logic             w_tc;

  // Reset gates busy directly so the outputs fall the moment reset rises,
  // independent of any clock edge. A zero period never runs.
  always_comb begin
    w_busy   = ~reset & enable & (per_q != '0) &
               ((mode == MODE_PERIODIC) | armed_q);
    // For per = 0 the subtraction wraps to all-ones, but busy is already low.
    w_tc     = (cnt_q == (per_q - c_one));
    busy     = w_busy;
    rollover = w_busy & w_tc;
  end

  // Next-state: load beats everything (including a coincident terminal
  // count, whose rollover is still visible this cycle); otherwise count only
  // while busy, and hold everything while idle.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    armed_d = armed_q;
    if (load) begin
      per_d   = period_in;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (w_busy) begin
      if (w_tc) begin
        cnt_d = '0;
        if (mode == MODE_ONESHOT) begin
          armed_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + c_one;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      per_q   <= c_rst_period;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      armed_q <= armed_d;
    end
  end

endmodule : timer_channel
`default_nettype wire

// File: rtl/timer_prog.sv
`default_nettype none
// ============================================================================
// Module      : timer_prog
// Description : Multi-channel programmable timer. CHANNELS independent
//               timer_channel instances share one period_in bus; each channel
//               has its own enable, mode and load strobe.
// Ports       : clk       - clock, state updates on rising edge
//               reset     - asynchronous active-high reset
//               enable    - [CHANNELS] per-channel count enable
//               mode      - [CHANNELS] per-channel mode (0 periodic/1 one-shot)
//               load      - [CHANNELS] per-channel load/restart strobe
//               period_in - [WIDTH] shared period value
//               rollover  - [CHANNELS] per-channel terminal-count pulse
//               busy      - [CHANNELS] per-channel running indicator
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prog
  import timer_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0] load,
  input  logic [WIDTH-1:0]    period_in,
  output logic [CHANNELS-1:0] rollover,
  output logic [CHANNELS-1:0] busy
);

  // The reset period must fit in WIDTH bits and at least one channel must
  // exist; anything else is a configuration error caught at elaboration.
  if (CHANNELS < 1 || (DEFAULT_PERIOD >> WIDTH) != 0) begin : g_param_check
    $error("timer_prog: illegal parameters (CHANNELS < 1 or DEFAULT_PERIOD too wide)");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable[g]),
      .mode      (mode[g]),
      .load      (load[g]),
      .period_in (period_in),
      .rollover  (rollover[g]),
      .busy      (busy[g])
    );
  end

endmodule : timer_prog
`default_nettype wire
